key_conditioner: RTL and testbench
==================================

# key_conditioner

Upstream conditioning stage for the DE0-Nano push-button path. It synchronises a raw, bouncing, active-low key and debounces it. It then emits clean single-cycle event pulses: press, release, long-press and auto-repeat. Downstream LED pattern logic uses these pulses as "step" / "advance" strobes instead of sampling the raw pin.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: stable-level time required to accept a press or release (20 ms at 50 MHz); legal ≥ 2.
- LONG_CYCLES, 50_000_000: debounced hold time before long_pulse (1 s); legal ≥ 2.
- REPEAT_CYCLES, 12_500_000: auto-repeat period after long-press (250 ms); legal ≥ 2.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz; the only clock.
- RESET_N  in  1  asynchronous, active-low reset; tied to KEY[0] at top level.
- KEY_IN  in  1  raw, asynchronous, active-low button (KEY[1]); 0 = pressed.
- key_level  out  1  debounced key state; 1 = pressed.
- press_pulse  out  1  one-cycle strobe on accepted press.
- release_pulse  out  1  one-cycle strobe on accepted release.
- long_pulse  out  1  one-cycle strobe when hold reaches LONG_CYCLES.
- repeat_pulse  out  1  one-cycle strobe every REPEAT_CYCLES while long-held.

## Operation
- KEY_IN passes through a 2-flop synchroniser. Both flops reset to 1 (released). The FSM sees only the synchronised signal `k`; `k=0` means pressed.
- Single counter `cnt`. Width = clog2(max(DEBOUNCE, LONG, REPEAT)) + 1. It is cleared on every state transition and increments by 1 otherwise. It never wraps, because each state exits at its terminal count.
- The FSM has five states. Reset state is RELEASED.
  - RELEASED: `k=0` → PRESS_DEB.
  - PRESS_DEB: `k=1` → RELEASED (bounce; no output). When `cnt==DEBOUNCE_CYCLES-1` with `k=0`, go to HELD and assert press_pulse and key_level.
  - HELD: `k=1` → RELEASE_DEB. When `cnt==LONG_CYCLES-1`, go to LONG_HELD, assert long_pulse and set `long_flag`.
  - LONG_HELD: `k=1` → RELEASE_DEB. When `cnt==REPEAT_CYCLES-1`, assert repeat_pulse, clear cnt and stay in LONG_HELD.
  - RELEASE_DEB: `k=0` → LONG_HELD if `long_flag`, else HELD. This is a bounce; no pulse is emitted, and the long/repeat timer restarts from 0. When `cnt==DEBOUNCE_CYCLES-1` with `k=1`, go to RELEASED, assert release_pulse, deassert key_level and clear `long_flag`.
- A `k` change and a terminal count in the same cycle resolve in favour of the `k` change. The pulse is not emitted.
- At most one of the four pulse outputs is high in any cycle.
- key_level stays 1 from press acceptance until release acceptance, including during RELEASE_DEB.

## Timing
- All outputs are registered. Reset values: key_level=0; all pulses=0; state RELEASED; cnt=0; long_flag=0.
- Press latency: press_pulse goes high in the cycle following rising edge N+3+DEBOUNCE_CYCLES. Edge N is the first edge at which KEY_IN is sampled low and held low.
- Release latency follows the same rule for KEY_IN high.
- long_pulse occurs LONG_CYCLES cycles after press_pulse. The first repeat_pulse occurs REPEAT_CYCLES after long_pulse, then periodically at the same interval.
- Every pulse is exactly one cycle wide.
- Reset asserted mid-operation: all state clears immediately and asynchronously, with no release_pulse. If the key is still held after RESET_N deasserts, a full press debounce runs again and a new press_pulse is produced.

## Structure
- Shared package key_cond_pkg holds:
  - the state enum (RELEASED, PRESS_DEB, HELD, LONG_HELD, RELEASE_DEB);
  - the default cycle constants;
  - a counter-width function.
- Sub-module sync_2ff: a 2-flop synchroniser with parameterised reset value. It is reused for any other asynchronous board inputs.
- key_conditioner instantiates sync_2ff and contains the FSM, counter and output registers.

## Test plan
Bench parameters: DEBOUNCE=4, LONG=20, REPEAT=8.
1. Clean press held for 10 cycles, then released → one press_pulse at edge N+7, key_level=1, no long_pulse; one release_pulse at release edge +7.
2. Press with a 2-cycle low glitch, then high → no pulses, and key_level stays 0 throughout.
3. Hold for 60 cycles → press_pulse at +7, long_pulse 20 cycles later, then repeat_pulses every 8 cycles. Release produces release_pulse, and long_flag is cleared (a following short press gives no long_pulse).
4. While in HELD, apply a 2-cycle high bounce → no release_pulse; key_level stays 1; the long timer restarts, so long_pulse is delayed by the bounce.
5. Assert RESET_N low mid-hold with the key held, then deassert → outputs go to 0 immediately; press_pulse reappears 7 cycles after deassertion.
6. Over a 10k-cycle random bounce soak, check that at most one pulse is high per cycle and that press/release pulses alternate strictly.

Source files
------------

// File: rtl/key_cond_pkg.sv
// Shared types and constants for the push-button conditioning path.
package key_cond_pkg;

   typedef enum logic [2:0] {
      RELEASED,
      PRESS_DEB,
      HELD,
      LONG_HELD,
      RELEASE_DEB
   } key_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
   localparam int DEF_LONG_CYCLES     = 50_000_000;
   localparam int DEF_REPEAT_CYCLES   = 12_500_000;

   // One spare bit above the largest terminal count.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      m = (m > c) ? m : c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous board inputs; reset value selectable
// so an idle level can be presented from reset.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// Debounces an active-low push button and emits press, release, long-press
// and auto-repeat strobes, each one cycle wide.
module key_conditioner
   import key_cond_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic CLOCK_50,
   input  logic RESET_N,
   input  logic KEY_IN,
   output logic key_level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse,
   output logic repeat_pulse
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES, REPEAT_CYCLES);
   localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
   localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

   logic          k;
   key_state_t    state;
   logic [CW-1:0] cnt;
   logic          long_flag;
   logic          lvl;
   logic          ev_press, ev_release, ev_long, ev_repeat;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk   (CLOCK_50),
      .rst_n (RESET_N),
      .d     (KEY_IN),
      .q     (k)
   );

   // A level change on k always wins over a terminal count in the same cycle.
   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         state      <= RELEASED;
         cnt        <= '0;
         long_flag  <= 1'b0;
         lvl        <= 1'b0;
         ev_press   <= 1'b0;
         ev_release <= 1'b0;
         ev_long    <= 1'b0;
         ev_repeat  <= 1'b0;
      end else begin
         ev_press   <= 1'b0;
         ev_release <= 1'b0;
         ev_long    <= 1'b0;
         ev_repeat  <= 1'b0;
         cnt        <= cnt + CW'(1);
         case (state)
            RELEASED: begin
               cnt <= '0;
               if (!k) state <= PRESS_DEB;
            end
            PRESS_DEB: begin
               if (k) begin
                  state <= RELEASED;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state    <= HELD;
                  cnt      <= '0;
                  lvl      <= 1'b1;
                  ev_press <= 1'b1;
               end
            end
            HELD: begin
               if (k) begin
                  state <= RELEASE_DEB;
                  cnt   <= '0;
               end else if (cnt == LONG_LAST) begin
                  state     <= LONG_HELD;
                  cnt       <= '0;
                  long_flag <= 1'b1;
                  ev_long   <= 1'b1;
               end
            end
            LONG_HELD: begin
               if (k) begin
                  state <= RELEASE_DEB;
                  cnt   <= '0;
               end else if (cnt == REP_LAST) begin
                  cnt       <= '0;
                  ev_repeat <= 1'b1;
               end
            end
            RELEASE_DEB: begin
               // Bounce back to holding restarts the long/repeat timer.
               if (!k) begin
                  state <= long_flag ? LONG_HELD : HELD;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state      <= RELEASED;
                  cnt        <= '0;
                  lvl        <= 1'b0;
                  long_flag  <= 1'b0;
                  ev_release <= 1'b1;
               end
            end
            default: begin
               state <= RELEASED;
               cnt   <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
      if (!RESET_N) begin
         key_level     <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
         long_pulse    <= 1'b0;
         repeat_pulse  <= 1'b0;
      end else begin
         key_level     <= lvl;
         press_pulse   <= ev_press;
         release_pulse <= ev_release;
         long_pulse    <= ev_long;
         repeat_pulse  <= ev_repeat;
      end
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed and random-bounce bench for key_conditioner against a run-length
// model of the button behaviour.
module tb_key_conditioner;

   localparam int D = 4;
   localparam int L = 20;
   localparam int R = 8;
   localparam int LAT = 3;   // sample edge to visible output

   logic CLOCK_50 = 1'b0;
   logic RESET_N  = 1'b0;
   logic KEY_IN   = 1'b1;
   logic key_level, press_pulse, release_pulse, long_pulse, repeat_pulse;

   int checks = 0;
   int errors = 0;

   key_conditioner #(
      .DEBOUNCE_CYCLES (D),
      .LONG_CYCLES     (L),
      .REPEAT_CYCLES   (R)
   ) dut (
      .CLOCK_50      (CLOCK_50),
      .RESET_N       (RESET_N),
      .KEY_IN        (KEY_IN),
      .key_level     (key_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .repeat_pulse  (repeat_pulse)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   // Model: run = consecutive samples disagreeing with the debounced level,
   // timer = edges held since acceptance / last bounce / last long or repeat.
   bit   m_level, m_long;
   int   m_run, m_timer;
   logic [4:0] dq [LAT];
   int   cyc, n_press, n_release, n_long, n_repeat, last_pulse;
   int   press_cyc, long_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_level = 0; m_long = 0; m_run = 0; m_timer = 0; last_pulse = 0;
      for (int i = 0; i < LAT; i++) dq[i] = '0;
   endtask

   task automatic model_step(input bit pressed, output logic [4:0] exp);
      bit p = 0, r = 0, lp = 0, rp = 0;
      if (pressed != m_level) begin
         m_run++;
         if (m_run == D + 1) begin
            m_level = pressed; m_run = 0; m_timer = 0;
            if (pressed) p = 1;
            else begin r = 1; m_long = 0; end
         end
      end else if (m_level) begin
         if (m_run > 0) begin
            m_run = 0; m_timer = 0;
         end else begin
            m_timer++;
            if (!m_long && m_timer == L) begin lp = 1; m_long = 1; m_timer = 0; end
            else if (m_long && m_timer == R) begin rp = 1; m_timer = 0; end
         end
      end else begin
         m_run = 0;
      end
      exp = dq[LAT-1];
      for (int i = LAT - 1; i > 0; i--) dq[i] = dq[i-1];
      dq[0] = {m_level, p, r, lp, rp};
   endtask

   task automatic step(input bit pressed, input string tag);
      logic [4:0] exp, obs;
      KEY_IN = ~pressed;
      @(posedge CLOCK_50);
      model_step(pressed, exp);
      #1;
      cyc++;
      obs = {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse};
      chk(tag, obs, exp);
      chk({tag, "_onehot"}, 32'($countones(obs[3:0]) <= 1), 1);
      if (obs[3]) begin
         chk({tag, "_alt_press"}, 32'(last_pulse == 1), 0);
         last_pulse = 1; n_press++; press_cyc = cyc;
      end
      if (obs[2]) begin
         chk({tag, "_alt_release"}, 32'(last_pulse == 2), 0);
         last_pulse = 2; n_release++;
      end
      if (obs[1]) begin n_long++; long_cyc = cyc; end
      if (obs[0]) n_repeat++;
   endtask

   task automatic hold(input bit pressed, input int n, input string tag);
      for (int i = 0; i < n; i++) step(pressed, tag);
   endtask

   initial begin
      int c0, np, nr, nl, nrep, len;
      bit lv;
      cyc = 0; n_press = 0; n_release = 0; n_long = 0; n_repeat = 0;
      press_cyc = 0; long_cyc = 0;
      model_reset();
      repeat (3) @(posedge CLOCK_50);
      #1;
      chk("reset_outputs", {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
      @(negedge CLOCK_50) RESET_N = 1'b1;
      hold(0, 5, "idle");

      // 1: clean short press and release
      c0 = cyc; np = n_press; nl = n_long; nr = n_release;
      hold(1, 10, "t1_press");
      chk("t1_press_latency", press_cyc - (c0 + 1), 7);
      c0 = cyc;
      hold(0, 20, "t1_release");
      chk("t1_press_count", n_press - np, 1);
      chk("t1_release_count", n_release - nr, 1);
      chk("t1_no_long", n_long - nl, 0);

      // 2: short glitch never accepted
      np = n_press;
      hold(1, 2, "t2_glitch");
      hold(0, 20, "t2_idle");
      chk("t2_no_press", n_press - np, 0);

      // 3: long hold with repeats, then a short press without long
      c0 = cyc; nl = n_long; nrep = n_repeat;
      hold(1, 60, "t3_hold");
      chk("t3_long_latency", long_cyc - (c0 + 1), 27);
      chk("t3_long_count", n_long - nl, 1);
      chk("t3_repeat_count", n_repeat - nrep, 4);
      hold(0, 20, "t3_release");
      nl = n_long;
      hold(1, 15, "t3_short");
      hold(0, 20, "t3_short_rel");
      chk("t3_long_cleared", n_long - nl, 0);

      // 4: release bounce in HELD restarts the long timer
      c0 = cyc; nl = n_long; nr = n_release;
      hold(1, 15, "t4_hold");
      hold(0, 2, "t4_bounce");
      hold(1, 40, "t4_hold2");
      chk("t4_no_release", n_release - nr, 0);
      chk("t4_long_delayed", long_cyc - (c0 + 1), 40);
      hold(0, 20, "t4_release");

      // 5: reset mid-hold
      nr = n_release;
      hold(1, 12, "t5_hold");
      @(negedge CLOCK_50) RESET_N = 1'b0;
      #1;
      chk("t5_async_clear", {key_level, press_pulse, release_pulse, long_pulse, repeat_pulse}, 0);
      repeat (2) @(posedge CLOCK_50);
      model_reset();
      @(negedge CLOCK_50) RESET_N = 1'b1;
      c0 = cyc;
      hold(1, 15, "t5_rehold");
      chk("t5_repress_latency", press_cyc - (c0 + 1), 7);
      chk("t5_no_release", n_release - nr, 0);
      hold(0, 20, "t5_release");

      // 6: random bounce soak
      c0 = cyc;
      lv = 0;
      while (cyc - c0 < 10000) begin
         lv = ~lv;
         len = (($urandom & 3) == 0) ? int'($urandom_range(1, 4)) : int'($urandom_range(1, 45));
         hold(lv, len, "soak");
      end
      hold(0, 20, "soak_end");
      chk("soak_final_level", key_level, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
